// File: rtl/axis_pixel_binarizer_packer.sv
// axis_pixel_binarizer_packer: binarizes 8-bit pixels against a per-image threshold and packs
// DATA_WIDTH bits per word, always emitting exactly IMG_ROWS words per image.
module axis_pixel_binarizer_packer #(
  parameter int PIXEL_WIDTH = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int IMG_ROWS    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIXEL_WIDTH-1:0] threshold,
  input  logic                   s_axis_valid,
  input  logic [PIXEL_WIDTH-1:0] s_axis_data,
  input  logic                   s_axis_last,
  output logic                   s_axis_ready,
  output logic                   m_axis_valid,
  output logic [DATA_WIDTH-1:0]  m_axis_data,
  output logic                   m_axis_last,
  input  logic                   m_axis_ready,
  output logic                   err_short,
  output logic                   err_long
);
  localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam int RW = IMG_ROWS > 1 ? $clog2(IMG_ROWS) : 1;
  typedef enum logic [1:0] {COLLECT, PAD, DISCARD} state_t;
  state_t                 state_q, state_d;
  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic [PIXEL_WIDTH-1:0] thr_q, thr_d;
  logic [DATA_WIDTH-1:0]  acc_q, acc_d, out_data_q, out_data_d, word;
  logic                   out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic                   err_short_q, err_short_d, err_long_q, err_long_d;
  logic                   col_max, row_max, first_px, rdy, acc_c, pix_bit;
  logic                   done, early, over, pad_load, load;
  always_comb begin
    col_max     = col_q == CW'(DATA_WIDTH - 1);
    row_max     = row_q == RW'(IMG_ROWS - 1);
    first_px    = col_q == '0 && row_q == '0;
    rdy         = state_q == DISCARD ||
                  (state_q == COLLECT && (!col_max || !out_valid_q || m_axis_ready));
    acc_c       = s_axis_valid && rdy && state_q == COLLECT;
    pix_bit     = s_axis_data >= (first_px ? threshold : thr_q);
    word        = acc_q | (DATA_WIDTH'(pix_bit) << col_q);
    done        = acc_c && col_max;
    early       = acc_c && s_axis_last && !(col_max && row_max);
    over        = done && row_max && !s_axis_last;
    // A truncated partial word waits in acc_q and leaves through PAD, since the
    // output register may still be occupied when the early last arrives.
    pad_load    = state_q == PAD && (!out_valid_q || m_axis_ready);
    load        = done || pad_load;
    out_data_d  = load ? (pad_load ? acc_q : word) : out_data_q;
    out_last_d  = load ? row_max : out_last_q;
    out_valid_d = load || (out_valid_q && !m_axis_ready);
    acc_d       = load ? '0 : acc_c ? word : acc_q;
    thr_d       = (acc_c && first_px) ? threshold : thr_q;
    col_d       = acc_c ? ((col_max || s_axis_last) ? '0 : col_q + CW'(1)) : col_q;
    row_d       = load ? (row_max ? '0 : row_q + RW'(1)) : row_q;
    err_short_d = early;
    err_long_d  = over;
    state_d     = state_q == COLLECT ? (early ? PAD : over ? DISCARD : COLLECT) :
                  state_q == PAD ? ((pad_load && row_max) ? COLLECT : PAD) :
                  (s_axis_valid && s_axis_last) ? COLLECT : DISCARD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      col_q       <= '0;
      row_q       <= '0;
      thr_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      thr_q       <= thr_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
    end
  end
  assign s_axis_ready = rdy && !rst;
  assign m_axis_valid = out_valid_q && !rst;
  assign m_axis_data  = rst ? '0 : out_data_q;
  assign m_axis_last  = out_last_q && !rst;
  assign err_short    = err_short_q && !rst;
  assign err_long     = err_long_q && !rst;
endmodule

// File: tb/tb_axis_pixel_binarizer_packer.sv
// tb_axis_pixel_binarizer_packer: randomized image streams scored against a per-image pixel model.
module tb_axis_pixel_binarizer_packer;
  localparam int DW = 32, IR = 32, NPIX = DW * IR;
  logic clk = 0, rst = 1;
  logic [7:0] threshold = 0, s_axis_data = 0;
  logic s_axis_valid = 0, s_axis_last = 0, s_axis_ready;
  logic m_axis_valid, m_axis_last, m_axis_ready = 0, err_short, err_long;
  logic [DW-1:0] m_axis_data;
  axis_pixel_binarizer_packer #(.PIXEL_WIDTH(8), .DATA_WIDTH(DW), .IMG_ROWS(IR)) dut (
    .clk(clk), .rst(rst), .threshold(threshold), .s_axis_valid(s_axis_valid),
    .s_axis_data(s_axis_data), .s_axis_last(s_axis_last), .s_axis_ready(s_axis_ready),
    .m_axis_valid(m_axis_valid), .m_axis_data(m_axis_data), .m_axis_last(m_axis_last),
    .m_axis_ready(m_axis_ready), .err_short(err_short), .err_long(err_long));
  always #5 clk = ~clk;
  typedef struct {logic [DW-1:0] d; logic l;} word_t;
  word_t exq[$];
  word_t mw;
  int n_err = 0, n_chk = 0, valid_pct = 100, rdy_pct = 100;
  int err_s_cnt = 0, err_l_cnt = 0, exp_s = 0, exp_l = 0, stall_cnt = 0;
  int pos = 0, fw, s0;
  bit disc = 0, stall_check = 0;
  logic [7:0] thr_m = 0;
  logic [DW-1:0] cur = 0;
  logic prev_stall = 0, prev_l = 0;
  logic [DW-1:0] prev_d = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void push_w(input logic [DW-1:0] d, input bit l);
    word_t w;
    w.d = d;
    w.l = l;
    exq.push_back(w);
  endfunction
  // Image-level reference: bits fill words LSB first, short images are zero padded to
  // IR words, over-long images keep the first NPIX pixels and drop up to the next last.
  function automatic void model_beat(input logic [7:0] d, input bit l, input logic [7:0] t);
    if (disc) begin
      if (l) disc = 0;
      return;
    end
    if (pos == 0) thr_m = t;
    cur[pos % DW] = d >= thr_m;
    pos++;
    if (pos % DW == 0) begin
      push_w(cur, pos == NPIX);
      cur = '0;
    end
    if (pos == NPIX) begin
      if (!l) begin
        disc = 1;
        exp_l++;
      end
      pos = 0;
    end else if (l) begin
      exp_s++;
      if (pos % DW != 0) begin
        push_w(cur, pos / DW == IR - 1);
        cur = '0;
        pos = (pos / DW + 1) * DW;
      end
      while (pos < NPIX) begin
        push_w('0, pos / DW == IR - 1);
        pos += DW;
      end
      pos = 0;
    end
  endfunction
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        chk("hold_valid", m_axis_valid, 1);
        chk("hold_data", m_axis_data, prev_d);
        chk("hold_last", m_axis_last, prev_l);
      end
      if (m_axis_valid && m_axis_ready) begin
        if (exq.size() == 0) chk("queue_nonempty", exq.size(), 1);
        else begin
          mw = exq.pop_front();
          chk("word_data", m_axis_data, mw.d);
          chk("word_last", m_axis_last, mw.l);
        end
      end
      err_s_cnt += int'(err_short);
      err_l_cnt += int'(err_long);
      stall_cnt += int'(s_axis_valid && !s_axis_ready);
      prev_stall = m_axis_valid && !m_axis_ready;
      prev_d = m_axis_data;
      prev_l = m_axis_last;
    end else prev_stall = 0;
  end
  initial forever begin
    @(posedge clk);
    #1 m_axis_ready = $urandom_range(99) < rdy_pct;
  end
  task automatic send_beat(input logic [7:0] d, input bit l, input logic [7:0] t, output int waits);
    bit acc = 0;
    waits = 0;
    s_axis_data = d;
    s_axis_last = l;
    threshold = t;
    while ($urandom_range(99) >= valid_pct) begin
      s_axis_valid = 0;
      @(posedge clk);
      #1;
    end
    s_axis_valid = 1;
    while (!acc && waits < 4000) begin
      @(negedge clk);
      acc = s_axis_ready;
      @(posedge clk);
      #1;
      waits++;
    end
    s_axis_valid = 0;
    if (!acc) chk("accept_timeout", acc, 1);
    else begin
      if (stall_check && waits > 1) chk("stall_pos", pos % DW, DW - 1);
      model_beat(d, l, t);
    end
  endtask
  task automatic send_img(input int len, input int last_at, input int kind, input int val,
                          input logic [7:0] ta, input int sw, input logic [7:0] tb2,
                          output int first_waits);
    int w;
    logic [7:0] px;
    first_waits = 0;
    for (int i = 0; i < len; i++) begin
      px = kind == 0 ? ((i % 2) ? 8'd255 : 8'd0) : kind == 1 ? 8'(val) : 8'($urandom_range(255));
      send_beat(px, i == last_at, i < sw ? ta : tb2, w);
      if (i == 0) first_waits = w;
    end
  endtask
  task automatic drain(input string tag);
    int n = 0;
    while (exq.size() != 0 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1 chk(tag, exq.size(), 0);
  endtask
  task automatic check_rst_outputs();
    @(negedge clk);
    chk("rst_s_ready", s_axis_ready, 0);
    chk("rst_m_valid", m_axis_valid, 0);
    chk("rst_m_data", m_axis_data, 0);
    chk("rst_m_last", m_axis_last, 0);
    chk("rst_err_short", err_short, 0);
    chk("rst_err_long", err_long, 0);
  endtask
  initial begin
    int lens[6] = '{1, 32, 700, 1024, 1040, 64};
    int len;
    @(posedge clk);
    #1 check_rst_outputs();
    @(posedge clk);
    #1 rst = 0;
    send_img(NPIX, NPIX - 1, 0, 0, 128, NPIX, 128, fw);
    s0 = stall_cnt;
    drain("t1_drain");
    chk("t1_no_stall", stall_cnt, 0);
    chk("t1_err_short", err_s_cnt, exp_s);
    chk("t1_err_long", err_l_cnt, exp_l);
    send_img(NPIX, NPIX - 1, 1, 128, 128, NPIX, 128, fw);
    send_img(NPIX, NPIX - 1, 1, 128, 129, NPIX, 129, fw);
    send_img(NPIX, NPIX - 1, 1, 128, 128, 500, 255, fw);
    send_img(NPIX, NPIX - 1, 2, 0, 8'($urandom_range(255)), 300, 8'($urandom_range(255)), fw);
    drain("t2_drain");
    valid_pct = 60;
    rdy_pct = 50;
    stall_check = 1;
    send_img(NPIX, NPIX - 1, 0, 0, 128, NPIX, 128, fw);
    send_img(NPIX, NPIX - 1, 2, 0, 8'($urandom_range(255)), NPIX, 0, fw);
    drain("t3_drain");
    stall_check = 0;
    chk("t3_err_short", err_s_cnt, exp_s);
    valid_pct = 100;
    rdy_pct = 100;
    send_img(40, 39, 1, 255, 128, NPIX, 128, fw);
    send_img(NPIX + 6, NPIX + 5, 1, 255, 128, NPIX, 128, fw);
    chk("t4_pad_stall", fw - 1, IR - 40 / DW);
    send_img(NPIX, NPIX - 1, 2, 0, 8'($urandom_range(255)), NPIX, 0, fw);
    drain("t5_drain");
    chk("t5_err_short", err_s_cnt, exp_s);
    chk("t5_err_long", err_l_cnt, exp_l);
    send_img(500, -1, 2, 0, 100, NPIX, 100, fw);
    drain("t6_pre_drain");
    rst = 1;
    check_rst_outputs();
    @(posedge clk);
    #1 rst = 0;
    pos = 0;
    cur = '0;
    disc = 0;
    send_img(NPIX, NPIX - 1, 2, 0, 8'($urandom_range(255)), NPIX, 0, fw);
    drain("t6_drain");
    valid_pct = 70;
    rdy_pct = 60;
    foreach (lens[i]) begin
      len = lens[i];
      send_img(len, len - 1, 2, 0, 8'($urandom_range(255)), NPIX, 0, fw);
    end
    send_img(NPIX, NPIX - 1, 2, 0, 8'($urandom_range(255)), NPIX, 0, fw);
    drain("rand_drain");
    chk("rand_err_short", err_s_cnt, exp_s);
    chk("rand_err_long", err_l_cnt, exp_l);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
